// File: rtl/instr_fill_ctrl_pkg.sv
// rtl/instr_fill_ctrl_pkg.sv - shared cache geometry and fill-state encoding
//
// Purpose: geometry constants for the instruction-cache fill path and the
//          state enum used by the line-fill controller.
// Ports:   none (package).

package cache_pkg;

   localparam int ADDR_SIZE        = 14;
   localparam int WORD_SIZE        = 32;
   localparam int WORDS_PER_LINE   = 8;
   localparam int WORD_OFFSET_BITS = $clog2(WORDS_PER_LINE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } fill_state_e;

endpackage

// File: rtl/instr_fill_ctrl_if.sv
// rtl/instr_fill_ctrl_if.sv - CPU / L1 / backing-memory signal bundle of the fill controller
//
// Purpose: groups the fetch request, L1 fill and memory read signals.
// Ports (modport master = fill controller side):
//   in : req_valid, req_addr, l1_hit, mem_gnt, mem_rvalid, mem_rdata
//   out: stall, mem_req, mem_addr, l1_we, l1_addr, l1_data, fill_done
// modport slave is the mirror image (CPU, L1 and memory side).

interface instr_fill_ctrl_if #(
   parameter int ADDR_SIZE = cache_pkg::ADDR_SIZE,
   parameter int WORD_SIZE = cache_pkg::WORD_SIZE
);

   logic                 req_valid;
   logic [ADDR_SIZE-1:0] req_addr;
   logic                 l1_hit;
   logic                 stall;

   logic                 mem_req;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic                 mem_gnt;
   logic                 mem_rvalid;
   logic [WORD_SIZE-1:0] mem_rdata;

   logic                 l1_we;
   logic [ADDR_SIZE-1:0] l1_addr;
   logic [WORD_SIZE-1:0] l1_data;
   logic                 fill_done;

   modport master (
      input  req_valid, req_addr, l1_hit, mem_gnt, mem_rvalid, mem_rdata,
      output stall, mem_req, mem_addr, l1_we, l1_addr, l1_data, fill_done
   );

   modport slave (
      output req_valid, req_addr, l1_hit, mem_gnt, mem_rvalid, mem_rdata,
      input  stall, mem_req, mem_addr, l1_we, l1_addr, l1_data, fill_done
   );

endinterface

// File: rtl/instr_fill_ctrl.sv
// rtl/instr_fill_ctrl.sv - instruction-cache line fill controller
//
// Purpose: on an L1 miss, requests the whole line from backing memory and
//          writes the returned beats into the L1 in offset order 0..N-1, so
//          the final-offset word (which flips the L1 LRU bit) lands last.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_fill_ctrl_if.master (fetch request, memory read, L1 fill)

module instr_fill_ctrl #(
   parameter int ADDR_SIZE      = cache_pkg::ADDR_SIZE,
   parameter int WORD_SIZE      = cache_pkg::WORD_SIZE,
   parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
   input logic                clk,
   input logic                reset_n,
   instr_fill_ctrl_if.master  bus
);

   import cache_pkg::*;

   localparam int                    OFF_BITS = $clog2(WORDS_PER_LINE);
   localparam logic [OFF_BITS-1:0]   LAST_OFF = OFF_BITS'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_SIZE-1:0]  OFF_MASK = ADDR_SIZE'(WORDS_PER_LINE - 1);

   fill_state_e           state_q, state_d;
   logic [ADDR_SIZE-1:0]  base_q, base_d;
   logic [OFF_BITS-1:0]   count_q, count_d;
   logic                  l1_we_q, l1_we_d;
   logic [ADDR_SIZE-1:0]  l1_addr_q, l1_addr_d;
   logic [WORD_SIZE-1:0]  l1_data_q, l1_data_d;

   logic                  miss;
   logic                  beat;

   // A miss is only acted on from IDLE; in other states the request is held
   // by the CPU through stall and the captured base is used instead.
   assign miss = bus.req_valid && !bus.l1_hit;
   assign beat = (state_q == ST_FILL) && bus.mem_rvalid;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (miss)        state_d = ST_REQ;
         ST_REQ:  if (bus.mem_gnt) state_d = ST_FILL;
         ST_FILL: if (beat && (count_q == LAST_OFF)) state_d = ST_DONE;
         // DONE always returns to IDLE so the L1 sees the completed line
         // before any new miss decision is taken.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------- outputs
   always_comb begin
      bus.mem_req   = (state_q == ST_REQ);
      bus.fill_done = (state_q == ST_DONE);
      bus.stall     = (state_q != ST_IDLE) || miss;
   end

   assign bus.mem_addr = base_q;
   assign bus.l1_we    = l1_we_q;
   assign bus.l1_addr  = l1_addr_q;
   assign bus.l1_data  = l1_data_q;

   // ------------------------------------------------------------ datapath
   always_comb begin
      base_d    = base_q;
      count_d   = count_q;
      l1_we_d   = 1'b0;
      l1_addr_d = l1_addr_q;
      l1_data_d = l1_data_q;
      case (state_q)
         ST_IDLE: begin
            if (miss) begin
               base_d = bus.req_addr & ~OFF_MASK;
            end
         end
         ST_REQ: begin
            if (bus.mem_gnt) begin
               count_d = '0;
            end
         end
         ST_FILL: begin
            // Memory returns beats in offset order, so the beat counter is
            // the word offset; it wraps after the last beat and is reloaded
            // on the next grant before it is used again.
            if (bus.mem_rvalid) begin
               l1_we_d   = 1'b1;
               l1_addr_d = base_q | {{(ADDR_SIZE - OFF_BITS){1'b0}}, count_q};
               l1_data_d = bus.mem_rdata;
               count_d   = count_q + OFF_BITS'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q    <= '0;
         count_q   <= '0;
         l1_we_q   <= 1'b0;
         l1_addr_q <= '0;
         l1_data_q <= '0;
      end else begin
         base_q    <= base_d;
         count_q   <= count_d;
         l1_we_q   <= l1_we_d;
         l1_addr_q <= l1_addr_d;
         l1_data_q <= l1_data_d;
      end
   end

endmodule

// File: tb/tb_instr_fill_ctrl.sv
// tb/tb_instr_fill_ctrl.sv - self-checking bench for instr_fill_ctrl

module tb_instr_fill_ctrl;

   logic clk;
   logic reset_n;
   logic force_hit;

   int n_vec;
   int n_err;

   instr_fill_ctrl_if bus ();

   instr_fill_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-way, four-set L1 reference: a line becomes valid when its final
   // word is written, replacing the LRU way and flipping that set's LRU bit.
   logic [8:0] tag_m [0:1][0:3];
   logic       vld_m [0:1][0:3];
   logic       lru_m [0:3];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < 4; s++) begin
            vld_m[0][s] <= 1'b0;
            vld_m[1][s] <= 1'b0;
            lru_m[s]    <= 1'b0;
         end
      end else if (bus.l1_we && (bus.l1_addr[2:0] == 3'd7)) begin
         vld_m[lru_m[bus.l1_addr[4:3]]][bus.l1_addr[4:3]] <= 1'b1;
         tag_m[lru_m[bus.l1_addr[4:3]]][bus.l1_addr[4:3]] <= bus.l1_addr[13:5];
         lru_m[bus.l1_addr[4:3]] <= !lru_m[bus.l1_addr[4:3]];
      end
   end

   always_comb begin
      bus.l1_hit = force_hit
                 | (vld_m[0][bus.req_addr[4:3]] && (tag_m[0][bus.req_addr[4:3]] == bus.req_addr[13:5]))
                 | (vld_m[1][bus.req_addr[4:3]] && (tag_m[1][bus.req_addr[4:3]] == bus.req_addr[13:5]));
   end

   function automatic logic model_hit(input logic [13:0] a);
      return (vld_m[0][a[4:3]] && (tag_m[0][a[4:3]] == a[13:5]))
          || (vld_m[1][a[4:3]] && (tag_m[1][a[4:3]] == a[13:5]));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One request that must hit: no memory traffic, no stall, no L1 writes.
   task automatic do_hit(input logic [13:0] a);
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      chk("hit_stall", 32'(bus.stall), 32'd0);
      chk("hit_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hit_mem_req2", 32'(bus.mem_req), 32'd0);
      chk("hit_l1_we", 32'(bus.l1_we), 32'd0);
      chk("hit_stall2", 32'(bus.stall), 32'd0);
   endtask

   // One complete miss. gap = idle cycles between beats; spurious drives
   // rvalid/gnt where they must be ignored; toggle moves req_addr during the
   // fill; abort_at != 0 pulls reset once that many beats have been written;
   // data_base != 0 selects data_base+offset instead of random beat data.
   task automatic do_fill(input logic [13:0] a, input int gnt_dly, input int gap,
                          input bit spurious, input bit toggle, input int abort_at,
                          input logic [31:0] data_base);
      logic [13:0] base;
      logic [31:0] prev_data;
      int          prev_idx;
      bit          prev_beat;
      bit          b;
      int          sent;
      int          nw;
      int          cyc;
      base      = a & ~14'h0007;
      prev_beat = 1'b0;
      prev_idx  = 0;
      prev_data = '0;
      sent      = 0;
      nw        = 0;
      cyc       = 0;

      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.mem_rvalid = spurious;
      bus.mem_gnt    = spurious;
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      chk("idle_stall", 32'(bus.stall), 32'd1);
      chk("idle_mem_req", 32'(bus.mem_req), 32'd0);

      for (int i = 0; i <= gnt_dly; i++) begin
         @(posedge clk); #1;
         bus.mem_gnt    = (i == gnt_dly);
         bus.mem_rvalid = spurious;
         bus.mem_rdata  = $urandom;
         @(negedge clk);
         chk("req_mem_req", 32'(bus.mem_req), 32'd1);
         chk("req_mem_addr", 32'(bus.mem_addr), 32'(base));
         chk("req_l1_we", 32'(bus.l1_we), 32'd0);
         chk("req_stall", 32'(bus.stall), 32'd1);
      end

      while (sent < 8 && cyc < 200) begin
         @(posedge clk); #1;
         bus.mem_gnt = 1'b0;
         if (toggle) bus.req_addr = 14'h3FF8;
         b = ((cyc % (gap + 1)) == gap);
         bus.mem_rvalid = b;
         bus.mem_rdata  = (data_base != 0) ? data_base + 32'(sent) : $urandom;
         @(negedge clk);
         nw += int'(bus.l1_we);
         chk("fill_l1_we", 32'(bus.l1_we), 32'(prev_beat));
         if (prev_beat) begin
            chk("fill_l1_addr", 32'(bus.l1_addr), 32'(base) + 32'(prev_idx));
            chk("fill_l1_data", bus.l1_data, prev_data);
         end
         chk("fill_mem_req", 32'(bus.mem_req), 32'd0);
         chk("fill_done_early", 32'(bus.fill_done), 32'd0);
         prev_beat = b;
         if (b) begin
            prev_idx  = sent;
            prev_data = bus.mem_rdata;
            sent++;
         end
         cyc++;
         if (abort_at != 0 && sent == abort_at) break;
      end

      if (abort_at != 0) begin
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
         chk("abort_last_we", 32'(bus.l1_we), 32'd1);
         chk("abort_last_addr", 32'(bus.l1_addr), 32'(base) + 32'(prev_idx));
         #2;
         reset_n       = 1'b0;
         bus.req_valid = 1'b0;
         #1;
         chk("rst_l1_we", 32'(bus.l1_we), 32'd0);
         chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
         chk("rst_fill_done", 32'(bus.fill_done), 32'd0);
         chk("rst_l1_addr", 32'(bus.l1_addr), 32'd0);
         chk("rst_l1_data", bus.l1_data, 32'd0);
         chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
         chk("rst_stall", 32'(bus.stall), 32'd0);
         @(posedge clk); #1;
         reset_n = 1'b1;
         @(negedge clk);
         chk("post_rst_stall", 32'(bus.stall), 32'd0);
         chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
         chk("post_rst_l1_we", 32'(bus.l1_we), 32'd0);
      end else begin
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
         bus.req_addr   = a;
         @(negedge clk);
         nw += int'(bus.l1_we);
         chk("done_l1_we", 32'(bus.l1_we), 32'd1);
         chk("done_l1_addr", 32'(bus.l1_addr), 32'(base) + 32'd7);
         chk("done_l1_data", bus.l1_data, prev_data);
         chk("done_pulse", 32'(bus.fill_done), 32'd1);
         chk("done_stall", 32'(bus.stall), 32'd1);
         @(posedge clk); #1;
         @(negedge clk);
         chk("after_done_pulse", 32'(bus.fill_done), 32'd0);
         chk("after_done_l1_we", 32'(bus.l1_we), 32'd0);
         chk("after_done_stall", 32'(bus.stall), 32'd0);
         chk("write_count", 32'(nw), 32'd8);
      end
   endtask

   initial begin
      logic [13:0] ra;
      n_vec          = 0;
      n_err          = 0;
      reset_n        = 1'b0;
      force_hit      = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      #3;
      chk("reset_stall", 32'(bus.stall), 32'd0);
      chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
      chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("reset_l1_we", 32'(bus.l1_we), 32'd0);
      chk("reset_l1_addr", 32'(bus.l1_addr), 32'd0);
      chk("reset_l1_data", bus.l1_data, 32'd0);
      chk("reset_fill_done", 32'(bus.fill_done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Forced hit: no line request at all.
      force_hit = 1'b1;
      do_hit(14'h0040);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      force_hit     = 1'b0;

      // Basic miss with delayed grant and known beat data.
      do_fill(14'h0123, 2, 0, 1'b0, 1'b0, 0, 32'hA0);
      // One beat every three cycles.
      do_fill(14'h0208, 1, 2, 1'b0, 1'b0, 0, 32'd0);
      // Spurious rvalid/gnt outside their states, req_addr moved during fill.
      do_fill(14'h0350, 1, 0, 1'b1, 1'b1, 0, 32'd0);
      // Reset after the fourth beat, then a fresh miss to the same line.
      do_fill(14'h0480, 0, 0, 1'b0, 1'b0, 4, 32'd0);
      do_fill(14'h0480, 0, 0, 1'b0, 1'b0, 0, 32'd0);

      // Two lines mapping to the same set both end up resident.
      do_fill(14'h0100, 1, 0, 1'b0, 1'b0, 0, 32'd0);
      do_fill(14'h0200, 0, 1, 1'b0, 1'b0, 0, 32'd0);
      do_hit(14'h0104);
      do_hit(14'h0207);

      // Random traffic over a small footprint so hits and evictions mix.
      for (int k = 0; k < 24; k++) begin
         ra = 14'($urandom_range(0, 127));
         if (model_hit(ra)) begin
            do_hit(ra);
         end else begin
            do_fill(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0, 0, 32'd0);
         end
      end

      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("final_stall", 32'(bus.stall), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
